// File: rtl/aes_dec_pkg.sv
// Shared types and helpers for the AES decryption round datapath.
// Provides state/byte widths, FSM encoding, InvShiftRows and byte selection.
package aes_dec_pkg;

   localparam int STATE_W  = 128;
   localparam int BYTE_W   = 8;
   localparam int NB_BYTES = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PROC = 2'd1,
      DONE = 2'd2
   } fsm_e;

   // Byte idx of the state; byte 0 is the most significant byte.
   function automatic logic [BYTE_W-1:0] byte_sel(
      input logic [STATE_W-1:0] s,
      input int unsigned        idx
   );
      return s[STATE_W-1-BYTE_W*idx -: BYTE_W];
   endfunction

   // s'[r][c] = s[r][(c-r) mod 4], with s[r][c] = byte r+4c.
   function automatic logic [STATE_W-1:0] inv_shift_rows(
      input logic [STATE_W-1:0] s
   );
      logic [STATE_W-1:0] o;
      o = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            o[STATE_W-1-BYTE_W*(r+4*c) -: BYTE_W] =
               byte_sel(s, r + 4*((c - r + 4) % 4));
         end
      end
      return o;
   endfunction

endpackage

// File: rtl/invSubBytes.sv
// Single-byte AES inverse S-box lookup (combinational).
// Ports: in_byte_i - input byte, out_byte_o - InvSubBytes(in_byte_i).
module invSubBytes (
   input  logic [7:0] in_byte_i,
   output logic [7:0] out_byte_o
);

   localparam logic [7:0] ISBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
      8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
      8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
      8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
      8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
      8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
      8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
      8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
      8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
      8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
      8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
      8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
      8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
      8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
      8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
      8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
      8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   assign out_byte_o = ISBOX[in_byte_i];

endmodule

// File: rtl/inv_shift_sub_stage.sv
// AES decryption round front end: capture + InvShiftRows, then in-place
// InvSubBytes over LANES bytes per cycle. Ports: CLK/RST, IN_* and OUT_*
// valid/ready/state handshakes (one block held at a time), BUSY.
module inv_shift_sub_stage
   import aes_dec_pkg::*;
#(
   parameter int LANES    = 4,
   parameter bit SHIFT_EN = 1'b1
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               IN_VALID,
   output logic               IN_READY,
   input  logic [STATE_W-1:0] IN_STATE,
   output logic               OUT_VALID,
   input  logic               OUT_READY,
   output logic [STATE_W-1:0] OUT_STATE,
   output logic               BUSY
);

   if (!(LANES == 1 || LANES == 2 || LANES == 4 ||
         LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("LANES must be 1, 2, 4, 8 or 16");
   end

   localparam int N  = NB_BYTES / LANES;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   fsm_e               state_q;
   logic [CW-1:0]      cnt_q;
   logic [STATE_W-1:0] work_q;
   logic [STATE_W-1:0] work_d;
   logic [STATE_W-1:0] cap_d;
   logic [STATE_W-1:0] out_state_q;
   logic               in_ready_q;
   logic               out_valid_q;
   logic               busy_q;

   logic [BYTE_W-1:0]  lane_in  [LANES];
   logic [BYTE_W-1:0]  lane_out [LANES];

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      assign lane_in[j] =
         byte_sel(work_q, int'(cnt_q) * LANES + j);
      invSubBytes u_isb (
         .in_byte_i  (lane_in[j]),
         .out_byte_o (lane_out[j])
      );
   end

   assign cap_d = SHIFT_EN ? inv_shift_rows(IN_STATE) : IN_STATE;

   // Current chunk written back in place; other bytes untouched.
   always_comb begin
      work_d = work_q;
      for (int j = 0; j < LANES; j++) begin
         work_d[STATE_W-1-BYTE_W*(int'(cnt_q)*LANES+j) -: BYTE_W] =
            lane_out[j];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         work_q      <= '0;
         out_state_q <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (IN_VALID && in_ready_q) begin
                  work_q     <= cap_d;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= PROC;
               end
            end
            PROC: begin
               work_q <= work_d;
               if (cnt_q == CNT_LAST) begin
                  cnt_q   <= '0;
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            DONE: begin
               // Result is published only once fully substituted.
               if (!out_valid_q) begin
                  out_valid_q <= 1'b1;
                  out_state_q <= work_q;
               end else if (OUT_READY) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign IN_READY  = in_ready_q;
   assign OUT_VALID = out_valid_q;
   assign OUT_STATE = out_state_q;
   assign BUSY      = busy_q;

endmodule
